cpu_data_register: RTL and testbench

- Parametrised, clocked successor to the CPU accumulator/index register.
- Serves as A, X, Y or S depending on parameters.
- Adds over the plain register: synchronous load, increment/decrement, decimal-adjust add, Z/N/wrap status, and a one-deep shadow for interrupt save/restore.
- Sits in the CPU datapath between the system bus and the internal data bus. Bus outputs use drive-qualified values instead of tristate.

---
 rtl/cpu_data_register.sv | 115 +++++++++++
 tb/tb_cpu_data_register.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_data_register.sv
// General-purpose CPU data register (A/X/Y/S): load, inc/dec, decimal-adjust add,
// Z/N/wrap status and an optional one-deep shadow for interrupt save/restore.
module cpu_data_register #(
  parameter int unsigned            WIDTH       = 8,
  parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
  parameter bit                     HAS_SHADOW  = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sys_bus_in,
  input  logic [WIDTH-1:0] dec_adj_in,
  input  logic             sys_load_en,
  input  logic             dec_adj_en,
  input  logic             inc_en,
  input  logic             dec_en,
  input  logic             save_en,
  input  logic             restore_en,
  input  logic             sys_out_en,
  input  logic             data_out_en,
  output logic [WIDTH-1:0] sys_bus_out,
  output logic             sys_bus_drive,
  output logic [WIDTH-1:0] data_bus_out,
  output logic             data_bus_drive,
  output logic [WIDTH-1:0] value,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             wrap_flag,
  output logic             saved_valid
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] value_q, value_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] shadow_q;
  logic             saved_valid_q;
  logic             restore_ok;
  logic [WIDTH:0]   adj_sum;

  // A restore only takes effect when the shadow actually holds something.
  assign restore_ok = HAS_SHADOW && restore_en && saved_valid_q;
  assign adj_sum    = {1'b0, value_q} + {1'b0, dec_adj_in};

  always_comb begin
    value_d = value_q;
    wrap_d  = 1'b0;
    if (restore_ok) begin
      value_d = shadow_q;
    end else if (sys_load_en) begin
      value_d = sys_bus_in;
    end else if (dec_adj_en) begin
      value_d = adj_sum[WIDTH-1:0];
      wrap_d  = adj_sum[WIDTH];
    end else if (inc_en && !dec_en) begin
      value_d = value_q + ONE;
      wrap_d  = &value_q;
    end else if (dec_en && !inc_en) begin
      value_d = value_q - ONE;
      wrap_d  = (value_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      wrap_q  <= wrap_d;
    end
  end

  generate
    if (HAS_SHADOW) begin : g_shadow
      logic [WIDTH-1:0] shadow_d;
      logic             saved_valid_d;

      // Save always captures the pre-edge value, so save+restore becomes a swap.
      always_comb begin
        shadow_d      = shadow_q;
        saved_valid_d = saved_valid_q;
        if (save_en) begin
          shadow_d      = value_q;
          saved_valid_d = 1'b1;
        end else if (restore_ok) begin
          saved_valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          shadow_q      <= '0;
          saved_valid_q <= 1'b0;
        end else begin
          shadow_q      <= shadow_d;
          saved_valid_q <= saved_valid_d;
        end
      end
    end else begin : g_no_shadow
      assign shadow_q      = '0;
      assign saved_valid_q = 1'b0;
    end
  endgenerate

  assign value          = value_q;
  assign zero_flag      = (value_q == '0);
  assign neg_flag       = value_q[WIDTH-1];
  assign wrap_flag      = wrap_q;
  assign saved_valid    = saved_valid_q;
  assign sys_bus_drive  = sys_out_en;
  assign data_bus_drive = data_out_en;
  assign sys_bus_out    = sys_out_en  ? value_q : '0;
  assign data_bus_out   = data_out_en ? value_q : '0;

endmodule

// File: tb/tb_cpu_data_register.sv
// Self-checking bench for cpu_data_register (8-bit, reset value FD, shadow present).
module tb_cpu_data_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sys_bus_in, dec_adj_in;
  logic       sys_load_en, dec_adj_en, inc_en, dec_en, save_en, restore_en;
  logic       sys_out_en, data_out_en;
  logic [7:0] sys_bus_out, data_bus_out, value;
  logic       sys_bus_drive, data_bus_drive, zero_flag, neg_flag, wrap_flag, saved_valid;

  int total = 0;
  int bad   = 0;

  // Reference state kept as plain integers.
  int m_val, m_shadow, m_wrap, m_sv;

  always #5 clk = ~clk;

  cpu_data_register #(.WIDTH(8), .RESET_VALUE(8'hFD), .HAS_SHADOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .sys_bus_in(sys_bus_in), .dec_adj_in(dec_adj_in),
    .sys_load_en(sys_load_en), .dec_adj_en(dec_adj_en),
    .inc_en(inc_en), .dec_en(dec_en),
    .save_en(save_en), .restore_en(restore_en),
    .sys_out_en(sys_out_en), .data_out_en(data_out_en),
    .sys_bus_out(sys_bus_out), .sys_bus_drive(sys_bus_drive),
    .data_bus_out(data_bus_out), .data_bus_drive(data_bus_drive),
    .value(value), .zero_flag(zero_flag), .neg_flag(neg_flag),
    .wrap_flag(wrap_flag), .saved_valid(saved_valid)
  );

  task automatic idle();
    rst_n = 1'b1;
    sys_load_en = 0; dec_adj_en = 0; inc_en = 0; dec_en = 0;
    save_en = 0; restore_en = 0; sys_out_en = 0; data_out_en = 0;
  endtask

  // Apply the architectural rules to the model, then advance one clock.
  task automatic step();
    int nv, nw, ns, nsv;
    nv = m_val; nw = 0; ns = m_shadow; nsv = m_sv;
    if (!rst_n) begin
      nv = 'hFD; ns = 0; nsv = 0;
    end else begin
      if (restore_en && m_sv == 1)       nv = m_shadow;
      else if (sys_load_en)              nv = sys_bus_in;
      else if (dec_adj_en) begin
        nv = (m_val + dec_adj_in) % 256;
        nw = (m_val + dec_adj_in > 255) ? 1 : 0;
      end else if (inc_en && !dec_en) begin
        nv = (m_val + 1) % 256;
        nw = (m_val == 255) ? 1 : 0;
      end else if (dec_en && !inc_en) begin
        nv = (m_val + 255) % 256;
        nw = (m_val == 0) ? 1 : 0;
      end
      if (save_en) begin
        ns = m_val; nsv = 1;
      end else if (restore_en && m_sv == 1) begin
        nsv = 0;
      end
    end
    m_val = nv; m_wrap = nw; m_shadow = ns; m_sv = nsv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    sys_load_en = 1; dec_adj_en = 1; inc_en = 1; dec_en = 1;
    save_en = 1; restore_en = 1; sys_out_en = 1; data_out_en = 1;
    sys_bus_in = 8'h5A; dec_adj_in = 8'hFF;
    step();
    total++; if (value !== 8'hFD) begin bad++; $display("FAIL reset_value got=%h exp=fd", value); end
    total++; if (saved_valid !== 1'b0) begin bad++; $display("FAIL reset_sv got=%b exp=0", saved_valid); end
    total++; if (wrap_flag !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%b exp=0", wrap_flag); end
    total++; if (zero_flag !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b exp=0", zero_flag); end
    total++; if (neg_flag !== 1'b1) begin bad++; $display("FAIL reset_neg got=%b exp=1", neg_flag); end
    idle();
  endtask

  task automatic test_load_bus();
    sys_load_en = 1; sys_bus_in = 8'h80;
    step();
    idle(); sys_out_en = 1;
    #1;
    total++; if (value !== 8'h80) begin bad++; $display("FAIL load_value got=%h exp=80", value); end
    total++; if (sys_bus_out !== 8'h80) begin bad++; $display("FAIL load_sysbus got=%h exp=80", sys_bus_out); end
    total++; if (sys_bus_drive !== 1'b1) begin bad++; $display("FAIL load_sysdrv got=%b exp=1", sys_bus_drive); end
    total++; if (data_bus_out !== 8'h00) begin bad++; $display("FAIL load_databus got=%h exp=00", data_bus_out); end
    total++; if (neg_flag !== 1'b1) begin bad++; $display("FAIL load_neg got=%b exp=1", neg_flag); end
    data_out_en = 1;
    #1;
    total++; if (data_bus_out !== 8'h80 || data_bus_drive !== 1'b1)
      begin bad++; $display("FAIL both_buses got=%h/%b exp=80/1", data_bus_out, data_bus_drive); end
    idle();
  endtask

  task automatic test_inc_dec_wrap();
    sys_load_en = 1; sys_bus_in = 8'hFF; step(); idle();
    inc_en = 1; step(); idle();
    total++; if (value !== 8'h00 || zero_flag !== 1'b1) begin bad++; $display("FAIL inc_wrap_value got=%h z=%b exp=00 z=1", value, zero_flag); end
    total++; if (wrap_flag !== 1'b1) begin bad++; $display("FAIL inc_wrap_flag got=%b exp=1", wrap_flag); end
    step();
    total++; if (wrap_flag !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle got=%b exp=0", wrap_flag); end
    dec_en = 1; step(); idle();
    total++; if (value !== 8'hFF || wrap_flag !== 1'b1) begin bad++; $display("FAIL dec_wrap got=%h w=%b exp=ff w=1", value, wrap_flag); end
    inc_en = 1; dec_en = 1; step(); idle();
    total++; if (value !== 8'hFF || wrap_flag !== 1'b0) begin bad++; $display("FAIL inc_dec_both got=%h w=%b exp=ff w=0", value, wrap_flag); end
  endtask

  task automatic test_dec_adj();
    sys_load_en = 1; sys_bus_in = 8'h9A; step(); idle();
    dec_adj_en = 1; dec_adj_in = 8'h66; step(); idle();
    total++; if (value !== 8'h00 || wrap_flag !== 1'b1) begin bad++; $display("FAIL decadj_carry got=%h w=%b exp=00 w=1", value, wrap_flag); end
    sys_load_en = 1; sys_bus_in = 8'h12; dec_adj_en = 1; step(); idle();
    total++; if (value !== 8'h12 || wrap_flag !== 1'b0) begin bad++; $display("FAIL load_beats_adj got=%h w=%b exp=12 w=0", value, wrap_flag); end
  endtask

  task automatic test_save_restore();
    sys_load_en = 1; sys_bus_in = 8'h42; step(); idle();
    save_en = 1; step(); idle();
    total++; if (saved_valid !== 1'b1) begin bad++; $display("FAIL save_sv got=%b exp=1", saved_valid); end
    sys_load_en = 1; sys_bus_in = 8'h07; step(); idle();
    restore_en = 1; step(); idle();
    total++; if (value !== 8'h42 || saved_valid !== 1'b0) begin bad++; $display("FAIL restore got=%h sv=%b exp=42 sv=0", value, saved_valid); end
    restore_en = 1; inc_en = 1; step(); idle();
    total++; if (value !== 8'h43) begin bad++; $display("FAIL restore_ignored got=%h exp=43", value); end
  endtask

  task automatic test_swap_reset();
    sys_load_en = 1; sys_bus_in = 8'h22; step(); idle();
    save_en = 1; step(); idle();
    sys_load_en = 1; sys_bus_in = 8'h11; step(); idle();
    save_en = 1; restore_en = 1; step(); idle();
    total++; if (value !== 8'h22 || saved_valid !== 1'b1) begin bad++; $display("FAIL swap got=%h sv=%b exp=22 sv=1", value, saved_valid); end
    save_en = 1; restore_en = 1; step(); idle();
    total++; if (value !== 8'h11 || saved_valid !== 1'b1) begin bad++; $display("FAIL swap_back got=%h sv=%b exp=11 sv=1", value, saved_valid); end
    rst_n = 0; save_en = 1; restore_en = 1; step(); idle();
    total++; if (value !== 8'hFD || saved_valid !== 1'b0) begin bad++; $display("FAIL reset_after_swap got=%h sv=%b exp=fd sv=0", value, saved_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 39) != 0);
      sys_load_en = ($urandom_range(0, 5) == 0);
      dec_adj_en  = ($urandom_range(0, 4) == 0);
      inc_en      = ($urandom_range(0, 2) == 0);
      dec_en      = ($urandom_range(0, 2) == 0);
      save_en     = ($urandom_range(0, 5) == 0);
      restore_en  = ($urandom_range(0, 4) == 0);
      sys_out_en  = $urandom_range(0, 1);
      data_out_en = $urandom_range(0, 1);
      sys_bus_in  = (i % 7 == 0) ? 8'hFF : 8'($urandom);
      dec_adj_in  = 8'($urandom);
      step();
      total++; if (value !== 8'(m_val)) begin bad++; $display("FAIL rnd_value i=%0d got=%h exp=%h", i, value, 8'(m_val)); end
      total++; if (wrap_flag !== 1'(m_wrap)) begin bad++; $display("FAIL rnd_wrap i=%0d got=%b exp=%0d", i, wrap_flag, m_wrap); end
      total++; if (saved_valid !== 1'(m_sv)) begin bad++; $display("FAIL rnd_sv i=%0d got=%b exp=%0d", i, saved_valid, m_sv); end
      total++; if (zero_flag !== (m_val == 0) || neg_flag !== (m_val >= 128))
        begin bad++; $display("FAIL rnd_flags i=%0d got z=%b n=%b val=%0d", i, zero_flag, neg_flag, m_val); end
      total++; if (sys_bus_out !== (sys_out_en ? 8'(m_val) : 8'h00) || sys_bus_drive !== sys_out_en)
        begin bad++; $display("FAIL rnd_sysbus i=%0d got=%h/%b val=%0d", i, sys_bus_out, sys_bus_drive, m_val); end
      total++; if (data_bus_out !== (data_out_en ? 8'(m_val) : 8'h00) || data_bus_drive !== data_out_en)
        begin bad++; $display("FAIL rnd_databus i=%0d got=%h/%b val=%0d", i, data_bus_out, data_bus_drive, m_val); end
    end
    idle();
  endtask

  initial begin
    idle();
    sys_bus_in = '0; dec_adj_in = '0;
    m_val = 0; m_shadow = 0; m_wrap = 0; m_sv = 0;
    @(negedge clk);
    test_reset();
    test_load_bus();
    test_inc_dec_wrap();
    test_dec_adj();
    test_save_restore();
    test_swap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
